// File: rtl/sha256_pkg.sv
// Shared types and widths for the SHA-256 request arbiter and its helpers.
package sha256_pkg;

    localparam int SHA256_MSG_W    = 256;
    localparam int SHA256_DIGEST_W = 256;

    typedef enum logic [1:0] {
        eIdle,
        eIssue,
        eWaitCore,
        eDeliver
    } sha256_arb_state_e;

endpackage

// File: rtl/sha256_rr_pick.sv
// Combinational round-robin picker: the search starts one past the pointer and wraps,
// returning a one-hot grant, its encoded index and whether any request is present.
module sha256_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    int cand;

    // NOTE: every output of a combinational block gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = |req_i;
        cand    = 0;
        // Walk from the farthest candidate to the nearest so the nearest hit is written last.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[cand]) begin
                idx_o = ID_W'(cand);
            end
        end
        if (any_o) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/sha256_req_arbiter.sv
// Shares one SHA-256 core among NUM_REQ requesters: round-robin accept, issue to the core,
// collect the digest and hand it back to the requester that owns the transaction.
module sha256_req_arbiter
    import sha256_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [NUM_REQ-1:0]                req_v_i,
    input  logic [NUM_REQ*SHA256_MSG_W-1:0]   req_msg_i,
    output logic [NUM_REQ-1:0]                req_ready_o,
    output logic [NUM_REQ-1:0]                resp_v_o,
    output logic [SHA256_DIGEST_W-1:0]        resp_digest_o,
    input  logic [NUM_REQ-1:0]                resp_yumi_i,
    output logic                              core_v_o,
    output logic [SHA256_MSG_W-1:0]           core_msg_o,
    input  logic                              core_ready_i,
    input  logic                              core_v_i,
    input  logic [SHA256_DIGEST_W-1:0]        core_digest_i,
    output logic                              core_yumi_o,
    output logic [ID_W-1:0]                   owner_o,
    output logic                              busy_o,
    output logic [15:0]                       done_count_o
);

    sha256_arb_state_e            state_q, state_d;
    logic [SHA256_MSG_W-1:0]      msg_q, msg_d;
    logic [SHA256_DIGEST_W-1:0]   digest_q, digest_d;
    logic [ID_W-1:0]              owner_q, owner_d;
    logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [15:0]                  done_count_q, done_count_d;

    logic [NUM_REQ-1:0]           pick_grant;
    logic [ID_W-1:0]              pick_idx;
    logic                         pick_any;

    sha256_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req_i   (req_v_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        msg_d        = msg_q;
        digest_d     = digest_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        done_count_d = done_count_q;
        req_ready_o  = '0;
        resp_v_o     = '0;
        core_v_o     = 1'b0;
        core_yumi_o  = 1'b0;

        unique case (state_q)
            eIdle: begin
                // The accept strobe is combinational, so it is gated while reset holds the block.
                if (pick_any && reset_n_i) begin
                    req_ready_o = pick_grant;
                    msg_d       = req_msg_i[int'(pick_idx)*SHA256_MSG_W +: SHA256_MSG_W];
                    owner_d     = pick_idx;
                    state_d     = eIssue;
                end
            end
            eIssue: begin
                core_v_o = 1'b1;
                if (core_ready_i) begin
                    state_d = eWaitCore;
                end
            end
            eWaitCore: begin
                core_yumi_o = core_v_i;
                if (core_v_i) begin
                    digest_d = core_digest_i;
                    state_d  = eDeliver;
                end
            end
            eDeliver: begin
                resp_v_o[owner_q] = 1'b1;
                if (resp_yumi_i[owner_q]) begin
                    rr_ptr_d     = owner_q;
                    done_count_d = done_count_q + 16'd1;
                    state_d      = eIdle;
                end
            end
            default: state_d = eIdle;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= eIdle;
            // NOTE: the wide message and digest holders are plain flops, not memories, and are cleared so the outputs they feed read zero in reset.
            msg_q        <= '0;
            digest_q     <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= ID_W'(NUM_REQ - 1);
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            msg_q        <= msg_d;
            digest_q     <= digest_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            done_count_q <= done_count_d;
        end
    end

    assign core_msg_o    = msg_q;
    assign resp_digest_o = digest_q;
    assign owner_o       = owner_q;
    assign busy_o        = (state_q != eIdle);
    assign done_count_o  = done_count_q;

endmodule
